// File: rtl/hazard_scoreboard_if.sv
// D-stage interface between the decode logic and the hazard scoreboard.
// The decode side (master) presents source/destination indices and timing
// codes; the scoreboard (slave) returns the stall and forwarding selects.
interface hazard_scoreboard_if #(
  parameter int REG_W = 5,
  parameter int T_W   = 4,
  parameter int MD_W  = 4
);
  logic [REG_W-1:0] rs_D;
  logic [REG_W-1:0] rt_D;
  logic [T_W-1:0]   tuse_rs_D;
  logic [T_W-1:0]   tuse_rt_D;
  logic [REG_W-1:0] a3_D;
  logic [T_W-1:0]   tnew_D;
  logic             md_use_D;
  logic             md_start_D;
  logic [MD_W-1:0]  md_lat_D;

  logic             stall;
  logic [1:0]       fwd_rs_D;
  logic [1:0]       fwd_rt_D;
  logic [1:0]       fwd_rs_E;
  logic [1:0]       fwd_rt_E;
  logic             md_busy;

  modport master (
    output rs_D, rt_D, tuse_rs_D, tuse_rt_D, a3_D, tnew_D,
           md_use_D, md_start_D, md_lat_D,
    input  stall, fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, md_busy
  );

  modport slave (
    input  rs_D, rt_D, tuse_rs_D, tuse_rt_D, a3_D, tnew_D,
           md_use_D, md_start_D, md_lat_D,
    output stall, fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, md_busy
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Tuse/Tnew hazard scoreboard for the 5-stage MIPS pipeline.
// Tracks in-flight producers through E/M/W with their remaining Tnew,
// plus the HI/LO multiply/divide busy counter, and produces the D-stage
// stall and the D/E forwarding selects (0 regfile, 1 from M, 2 from W).
module hazard_scoreboard #(
  parameter int REG_W = 5,
  parameter int T_W   = 4,
  parameter int MD_W  = 4
) (
  input logic               clk,
  input logic               reset,
  hazard_scoreboard_if.slave sb
);

  // Pipeline slot state; Tnew is stored relative to the stage it sits in.
  logic [REG_W-1:0] a3_e_q, a3_e_d;
  logic [T_W-1:0]   tnew_e_q, tnew_e_d;
  logic [REG_W-1:0] rs_e_q, rs_e_d;
  logic [REG_W-1:0] rt_e_q, rt_e_d;
  logic [REG_W-1:0] a3_m_q, a3_m_d;
  logic [T_W-1:0]   tnew_m_q, tnew_m_d;
  logic [REG_W-1:0] a3_w_q, a3_w_d;
  logic [MD_W-1:0]  md_cnt_q, md_cnt_d;

  logic stall;
  logic reg_haz_rs, reg_haz_rt, md_haz;

  // Register 0 is hardwired, so it never creates a dependency.
  function automatic logic match(input logic [REG_W-1:0] x,
                                 input logic [REG_W-1:0] a);
    return (x != '0) && (x == a);
  endfunction

  function automatic logic [T_W-1:0] sat_dec(input logic [T_W-1:0] t);
    return (t == '0) ? '0 : t - T_W'(1);
  endfunction

  // M wins over W because it holds the newer value; E is never a source
  // since no result is complete while the producer is still in E.
  function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src);
    if (match(src, a3_m_q) && (tnew_m_q == '0)) return 2'd1;
    else if (match(src, a3_w_q))                return 2'd2;
    else                                        return 2'd0;
  endfunction

  // Stall when a source is needed before its producer can supply it,
  // or when the md unit is still busy.
  always_comb begin
    reg_haz_rs = (match(sb.rs_D, a3_e_q) && (sb.tuse_rs_D < tnew_e_q)) ||
                 (match(sb.rs_D, a3_m_q) && (sb.tuse_rs_D < tnew_m_q));
    reg_haz_rt = (match(sb.rt_D, a3_e_q) && (sb.tuse_rt_D < tnew_e_q)) ||
                 (match(sb.rt_D, a3_m_q) && (sb.tuse_rt_D < tnew_m_q));
    md_haz     = sb.md_use_D && (md_cnt_q != '0);
    stall      = reg_haz_rs || reg_haz_rt || md_haz;
  end

  assign sb.stall    = stall;
  assign sb.fwd_rs_D = fwd_sel(sb.rs_D);
  assign sb.fwd_rt_D = fwd_sel(sb.rt_D);
  assign sb.fwd_rs_E = fwd_sel(rs_e_q);
  assign sb.fwd_rt_E = fwd_sel(rt_e_q);
  assign sb.md_busy  = (md_cnt_q != '0);

  // Next-state: slots advance every cycle; a stall inserts a bubble into E.
  always_comb begin
    a3_m_d   = a3_e_q;
    tnew_m_d = sat_dec(tnew_e_q);
    a3_w_d   = a3_m_q;
    a3_e_d   = '0;
    tnew_e_d = '0;
    rs_e_d   = '0;
    rt_e_d   = '0;
    if (!stall) begin
      a3_e_d   = sb.a3_D;
      tnew_e_d = sat_dec(sb.tnew_D);
      rs_e_d   = sb.rs_D;
      rt_e_d   = sb.rt_D;
    end
    md_cnt_d = md_cnt_q;
    // A new mult/div cannot leave D while the counter is nonzero (it stalls),
    // so load and decrement are mutually exclusive in practice.
    if (sb.md_start_D && !stall) md_cnt_d = sb.md_lat_D;
    else if (md_cnt_q != '0)     md_cnt_d = md_cnt_q - MD_W'(1);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      a3_e_q   <= '0;
      tnew_e_q <= '0;
      rs_e_q   <= '0;
      rt_e_q   <= '0;
      a3_m_q   <= '0;
      tnew_m_q <= '0;
      a3_w_q   <= '0;
      md_cnt_q <= '0;
    end else begin
      a3_e_q   <= a3_e_d;
      tnew_e_q <= tnew_e_d;
      rs_e_q   <= rs_e_d;
      rt_e_q   <= rt_e_d;
      a3_m_q   <= a3_m_d;
      tnew_m_q <= tnew_m_d;
      a3_w_q   <= a3_w_d;
      md_cnt_q <= md_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard. The reference model keeps the raw
// decode-time Tnew of each instruction that left D in the last three cycles
// (indexed by age) and the cycle until which the md unit is busy.
module tb_hazard_scoreboard;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.REG_W(5), .T_W(4), .MD_W(4)) sbif ();

  hazard_scoreboard #(.REG_W(5), .T_W(4), .MD_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .sb    (sbif)
  );

  typedef struct {
    logic       stall;
    logic [1:0] frsd;
    logic [1:0] frtd;
    logic [1:0] frse;
    logic [1:0] frte;
    logic       busy;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Model state: history of what left D, age 1 (now in E) .. age 3 (now in W).
  int h_a3[1:3];
  int h_tnew[1:3];
  int h_rs[1:3];
  int h_rt[1:3];
  int cyc        = 0;
  int busy_until = -1;
  bit model_ok   = 0;

  function automatic bit m_haz(int src, int tuse);
    for (int age = 1; age <= 2; age++)
      if (src != 0 && src == h_a3[age] && (tuse + age) < h_tnew[age]) return 1;
    return 0;
  endfunction

  // Result of a producer that left D two cycles ago is ready iff its Tnew <= 2.
  function automatic logic [1:0] m_fwd(int src);
    if (src != 0 && src == h_a3[2] && h_tnew[2] <= 2) return 2'd1;
    if (src != 0 && src == h_a3[3])                   return 2'd2;
    return 2'd0;
  endfunction

  function automatic exp_t model_eval();
    exp_t e;
    e.stall = m_haz(int'(sbif.rs_D), int'(sbif.tuse_rs_D)) ||
              m_haz(int'(sbif.rt_D), int'(sbif.tuse_rt_D)) ||
              (sbif.md_use_D && busy_until >= cyc);
    e.frsd  = m_fwd(int'(sbif.rs_D));
    e.frtd  = m_fwd(int'(sbif.rt_D));
    e.frse  = m_fwd(h_rs[1]);
    e.frte  = m_fwd(h_rt[1]);
    e.busy  = (busy_until >= cyc);
    return e;
  endfunction

  exp_t last_exp;

  task automatic drive(input bit rst, input int rs, input int rt,
                       input int tu_rs, input int tu_rt, input int a3,
                       input int tnew, input bit mu, input bit ms, input int lat);
    reset           = ~rst;
    sbif.rs_D       = 5'(rs);
    sbif.rt_D       = 5'(rt);
    sbif.tuse_rs_D  = 4'(tu_rs);
    sbif.tuse_rt_D  = 4'(tu_rt);
    sbif.a3_D       = 5'(a3);
    sbif.tnew_D     = 4'(tnew);
    sbif.md_use_D   = mu;
    sbif.md_start_D = ms;
    sbif.md_lat_D   = 4'(lat);
    last_exp = model_eval();
    if (model_ok) exp_q.push_back(last_exp);
    @(posedge clk);
    if (rst) begin
      for (int a = 1; a <= 3; a++) begin
        h_a3[a] = 0; h_tnew[a] = 0; h_rs[a] = 0; h_rt[a] = 0;
      end
      busy_until = cyc;
      model_ok   = 1;
    end else begin
      for (int a = 3; a >= 2; a--) begin
        h_a3[a] = h_a3[a-1]; h_tnew[a] = h_tnew[a-1];
        h_rs[a] = h_rs[a-1]; h_rt[a]   = h_rt[a-1];
      end
      if (last_exp.stall) begin
        h_a3[1] = 0; h_tnew[1] = 0; h_rs[1] = 0; h_rt[1] = 0;
      end else begin
        h_a3[1] = a3; h_tnew[1] = tnew; h_rs[1] = rs; h_rt[1] = rt;
        if (ms) busy_until = cyc + lat;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic nop();
    drive(0, 0, 0, 3, 3, 0, 0, 0, 0, 0);
  endtask

  task automatic chk(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, expv);
    end
  endtask

  // Monitor: one expected record per checked cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("stall",    int'(sbif.stall),    int'(e.stall));
      chk("fwd_rs_D", int'(sbif.fwd_rs_D), int'(e.frsd));
      chk("fwd_rt_D", int'(sbif.fwd_rt_D), int'(e.frtd));
      chk("fwd_rs_E", int'(sbif.fwd_rs_E), int'(e.frse));
      chk("fwd_rt_E", int'(sbif.fwd_rt_E), int'(e.frte));
      chk("md_busy",  int'(sbif.md_busy),  int'(e.busy));
    end
  end

  initial begin
    reset = 1'b1;
    #1;
    // Reset held two cycles with a producer on the D inputs, then a reader.
    drive(1, 0, 0, 0, 0, 5, 3, 1, 1, 9);
    drive(1, 0, 0, 0, 0, 5, 3, 1, 1, 9);
    drive(0, 5, 0, 0, 3, 0, 0, 1, 0, 0);
    nop(); nop(); nop();

    // Load-use: lw $8, then beq $8 (tuse 0) held in D until it issues.
    drive(0, 0, 0, 3, 3, 8, 3, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 8, 0, 0, 3, 0, 0, 0, 0, 0);
    nop(); nop(); nop();

    // ALU-use: addu $3, addu reading $3 (tuse 1), then a beq reader.
    drive(0, 1, 2, 1, 1, 3, 2, 0, 0, 0);
    drive(0, 3, 2, 1, 1, 4, 2, 0, 0, 0);
    drive(0, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    nop(); nop(); nop();

    // $0 destination never hazards or forwards.
    drive(0, 0, 0, 1, 1, 0, 2, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    nop(); nop(); nop();

    // mult (lat 5), mfhi repeated until it issues, then div issued while busy.
    drive(0, 1, 2, 1, 1, 0, 0, 1, 1, 5);
    for (int i = 0; i < 7; i++) drive(0, 0, 0, 3, 3, 9, 2, 1, 0, 0);
    drive(0, 1, 2, 1, 1, 0, 0, 1, 1, 10);
    drive(0, 1, 2, 1, 1, 0, 0, 1, 1, 3);
    for (int i = 0; i < 12; i++) drive(0, 1, 2, 1, 1, 0, 0, 1, 1, 3);
    for (int i = 0; i < 5; i++) nop();

    // Priority: $7 written twice back-to-back, reader sees the newer (M).
    drive(0, 0, 0, 3, 3, 7, 2, 0, 0, 0);
    drive(0, 0, 0, 3, 3, 7, 2, 0, 0, 0);
    nop();
    drive(0, 0, 7, 3, 1, 0, 0, 0, 0, 0);
    nop(); nop(); nop();

    // Randomized traffic over a small register set to force collisions.
    for (int i = 0; i < 4000; i++) begin
      bit rst, mu, ms;
      rst = ($urandom_range(0, 199) == 0);
      mu  = ($urandom_range(0, 5) == 0);
      ms  = mu && ($urandom_range(0, 1) == 1);
      drive(rst, $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 4),
            mu, ms, $urandom_range(1, 12));
    end

    @(negedge clk);
    @(negedge clk);
    chk("queue_drain", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
